pipelined_data_memory: RTL

//  Clocked, parametrised word memory with start/ready request handshake,

---
 rtl/pipelined_data_memory.sv | 89 ++++++++
 1 files changed

// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: latency-programmable word memory with start/ready handshake, range checks; MEMORY_BYTE_WRITE_EN enables byte-lane writes
module pipelined_data_memory #(
  parameter int WORD_SIZE = 32,
  parameter int MEMORY_SIZE = 1024,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic                   write_enabled,
  input  logic                   read_enabled,
  input  logic [WORD_SIZE/8-1:0] byte_enable,
  input  logic [WORD_SIZE-1:0]   address,
  input  logic [WORD_SIZE-1:0]   input_data,
  output logic                   valid,
  output logic [WORD_SIZE-1:0]   output_data,
  output logic                   err_invalid_address
);
  localparam int NB = WORD_SIZE / 8;
  localparam int OB = $clog2(NB);
  localparam int MW = $clog2(MEMORY_SIZE);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam int IW = WORD_SIZE - OB + 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
  localparam logic [IW-1:0] DEPTH = IW'(MEMORY_SIZE);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];
  logic [CW-1:0] count;
  logic wr_q, rd_q;
  logic [NB-1:0] be_q;
  logic [WORD_SIZE-1:0] addr_q, data_q;
  logic idle, fin, cur_wr, cur_rd, bad;
  logic [NB-1:0] cur_be;
  logic [WORD_SIZE-1:0] cur_addr, cur_data, word, mask, merged, rdata;
  logic [MW-1:0] widx;
  // With LATENCY=1 the request completes on its accept edge, so the live inputs stand in for the latched copy
  assign idle = state == IDLE;
  assign cur_wr = idle ? write_enabled : wr_q;
  assign cur_rd = idle ? read_enabled : rd_q;
  assign cur_be = idle ? byte_enable : be_q;
  assign cur_addr = idle ? address : addr_q;
  assign cur_data = idle ? input_data : data_q;
  assign widx = cur_addr[OB +: MW];
  assign bad = |cur_addr[OB-1:0] || {1'b0, cur_addr[WORD_SIZE-1:OB]} >= DEPTH;
  assign word = mem[widx];
  assign fin = idle ? start && LATENCY == 1 : state == WAIT && count + CW'(1) == LAST;
`ifdef MEMORY_BYTE_WRITE_EN
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign mask[8*i +: 8] = {8{cur_be[i]}};
  end
`else
  logic unused_be;
  assign mask = '1;
  assign unused_be = ^cur_be;
`endif
  assign merged = (cur_data & mask) | (word & ~mask);
  assign rdata = cur_wr ? merged : word;
  always_ff @(posedge clk) begin
    if (idle && start) begin
      wr_q <= write_enabled;
      rd_q <= read_enabled;
      be_q <= byte_enable;
      addr_q <= address;
      data_q <= input_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && fin && cur_wr && !bad) mem[widx] <= merged;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      err_invalid_address <= 1'b0;
      output_data <= '0;
      count <= '0;
    end else begin
      state <= fin ? DONE : idle ? (start ? WAIT : IDLE) : state == WAIT ? WAIT : IDLE;
      ready <= !fin && (idle ? !start : state == DONE);
      valid <= fin;
      err_invalid_address <= fin && bad;
      count <= state == WAIT ? count + CW'(1) : '0;
      if (fin && (bad || cur_rd)) output_data <= bad ? '0 : rdata;
    end
  end
endmodule
